// File: rtl/bitcoin_pkg.sv
// Shared definitions for the parallel bitcoin hash datapath: word type,
// SHA-256 block geometry, padding constants, loader FSM states and the K table.
`timescale 1ns/1ps
package bitcoin_pkg;

   typedef logic [31:0] word_t;

   localparam int    SHA_BLOCK_WORDS = 16;
   localparam word_t PAD_WORD        = 32'h8000_0000;
   localparam int    NONCE_WORD_IDX  = 3;

   // Capture array holds block 1 followed by the block-2 template.
   localparam int    CAP_WORDS       = 2 * SHA_BLOCK_WORDS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } ldr_state_t;

   localparam word_t SHA_K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

endpackage

// File: rtl/bitcoin_header_loader.sv
// Header fetch stage: streams the 19-word block header out of SRAM and
// assembles SHA-256 block 1 plus the padded block-2 template, then offers
// both to the nonce engines over a valid/ready handshake. Read-only on memory.
`timescale 1ns/1ps
module bitcoin_header_loader
   import bitcoin_pkg::*;
#(
   parameter int HEADER_WORDS = 19,
   parameter int MSG_BITS     = 640,
   parameter int ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] message_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_read_data,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [511:0]      blk1,
   output logic [511:0]      blk2
);

   localparam int               IDX_W    = $clog2(CAP_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEADER_WORDS - 1);

   ldr_state_t        r_state;
   logic [ADDR_W-1:0] r_base;
   logic [IDX_W-1:0]  r_rd_idx;
   logic [IDX_W-1:0]  r_cap_idx;
   logic              r_cap_en;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_busy;
   logic              r_out_valid;
   word_t             r_words [0:CAP_WORDS-1];

   // Control FSM: issues one read address per cycle and tracks the capture slot one cycle behind.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_base      <= '0;
         r_rd_idx    <= '0;
         r_cap_idx   <= '0;
         r_cap_en    <= 1'b0;
         r_mem_addr  <= '0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_base     <= message_addr;
                  r_rd_idx   <= '0;
                  r_mem_addr <= message_addr;
                  r_busy     <= 1'b1;
                  r_state    <= ST_READ;
               end
            end
            ST_READ: begin
               // The word addressed now returns next cycle, so its slot is remembered here.
               r_cap_en  <= 1'b1;
               r_cap_idx <= r_rd_idx;
               if (r_rd_idx == LAST_IDX) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_rd_idx   <= r_rd_idx + IDX_W'(1);
                  // Address arithmetic deliberately wraps at the top of the address space.
                  r_mem_addr <= r_base + ADDR_W'(r_rd_idx) + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               r_cap_en    <= 1'b0;
               r_out_valid <= 1'b1;
               r_state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Capture array: fixed block-2 fields are laid down at start, header words land as they return.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < CAP_WORDS; i++) begin
            r_words[i] <= '0;
         end
      end else begin
         if ((r_state == ST_IDLE) && start) begin
            for (int i = HEADER_WORDS; i < CAP_WORDS; i++) begin
               r_words[i] <= '0;
            end
            r_words[SHA_BLOCK_WORDS + NONCE_WORD_IDX]     <= '0;
            r_words[SHA_BLOCK_WORDS + NONCE_WORD_IDX + 1] <= PAD_WORD;
            r_words[CAP_WORDS - 1]                        <= word_t'(MSG_BITS);
         end
         if (r_cap_en) begin
            r_words[r_cap_idx] <= mem_read_data;
         end
      end
   end

   // Word 0 of each block sits in the most significant 32 bits.
   for (genvar g = 0; g < SHA_BLOCK_WORDS; g++) begin : g_pack
      assign blk1[32*(SHA_BLOCK_WORDS-1-g) +: 32] = r_words[g];
      assign blk2[32*(SHA_BLOCK_WORDS-1-g) +: 32] = r_words[SHA_BLOCK_WORDS + g];
   end

   assign mem_addr  = r_mem_addr;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bitcoin_header_loader.sv
// Randomised scoreboard bench for bitcoin_header_loader: a reference model
// builds the expected blocks from the memory image when a fetch is started,
// and an independent monitor compares whatever the loader presents.
`timescale 1ns/1ps
module tb_bitcoin_header_loader;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [15:0]  message_addr;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_read_data;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] blk1;
   logic [511:0] blk2;

   logic [31:0]   mem [0:65535];
   logic [1023:0] sb_q [$];
   int            n_checks = 0;
   int            n_errors = 0;

   bitcoin_header_loader dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .message_addr  (message_addr),
      .mem_addr      (mem_addr),
      .mem_read_data (mem_read_data),
      .busy          (busy),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .blk1          (blk1),
      .blk2          (blk2)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM read port: data follows the address by one cycle.
   always @(posedge clk) begin
      mem_read_data <= mem[mem_addr];
   end

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
   endfunction

   // Expected blocks: 16 header words for block 1; header words 16..18,
   // zero nonce, the 0x80 pad marker, zeros and the 640-bit length for block 2.
   function automatic logic [1023:0] ref_blocks(input logic [15:0] base);
      logic [511:0] b1;
      logic [511:0] b2;
      logic [15:0]  a;
      logic [31:0]  h16, h17, h18;
      b1 = '0;
      for (int i = 0; i < 16; i++) begin
         a  = base + 16'(i);
         b1 = {b1[479:0], mem[a]};
      end
      a = base + 16'd16; h16 = mem[a];
      a = base + 16'd17; h17 = mem[a];
      a = base + 16'd18; h18 = mem[a];
      b2 = {h16, h17, h18, 32'h0, 32'h8000_0000, 320'h0, 32'd640};
      return {b1, b2};
   endfunction

   // Monitor: looks just after the falling edge, once stimulus for the
   // coming rising edge has settled, and retires an entry on a handshake.
   always begin
      logic [1023:0] exp_v;
      @(negedge clk);
      #2;
      if (reset_n && out_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid got 1 want 0");
         end else begin
            exp_v = sb_q[0];
            check("sb_blk1", blk1, exp_v[1023:512]);
            check("sb_blk2", blk2, exp_v[511:0]);
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   // One full fetch. Called just after a falling edge with the loader idle
   // (or returning to idle on the coming edge); the next rising edge is edge 0.
   task automatic txn(input logic [15:0] base, input int pulse_at, input bit hs_start,
                      input int stall, input bit t1);
      logic [15:0] ea;
      sb_q.push_back(ref_blocks(base));
      start        = 1'b1;
      message_addr = base;
      out_ready    = (stall == 0);
      @(posedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("fetch_busy_novalid", {511'b0, busy & ~out_valid}, 512'd1);
         if (k < 19) begin
            ea = base + 16'(k);
            check("mem_addr", {496'b0, mem_addr}, {496'b0, ea});
         end
         start = (k == pulse_at);
         if (k == pulse_at) message_addr = base ^ 16'h5A5A;
         @(posedge clk);
      end
      start = 1'b0;
      @(negedge clk);
      check("valid_rise", {510'b0, out_valid, busy}, 512'd3);
      if (t1) begin
         check("t1_blk1_w0", {480'b0, blk1[511:480]}, 512'h0123_4567);
         check("t1_blk1_w1", {480'b0, blk1[479:448]}, 512'h0246_8ACE);
         check("t1_blk2_w0", {480'b0, blk2[511:480]}, 512'h4567_0123);
         check("t1_blk2_w4", {480'b0, blk2[383:352]}, 512'h8000_0000);
         check("t1_blk2_w15", {480'b0, blk2[31:0]}, 512'h0000_0280);
      end
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold", {510'b0, out_valid, busy}, 512'd3);
      end
      out_ready = 1'b1;
      if (hs_start) begin
         start        = 1'b1;
         message_addr = base + 16'd1;
      end
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      check("done_idle", {510'b0, out_valid, busy}, 512'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] b;
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      reset_n      = 1'b0;
      start        = 1'b0;
      message_addr = '0;
      out_ready    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctl", {494'b0, mem_addr, out_valid, busy}, 512'd0);
      check("rst_blk1", blk1, 512'd0);
      check("rst_blk2", blk2, 512'd0);
      reset_n = 1'b1;

      // Known pattern at address 0 with a short stall.
      for (int i = 0; i < 19; i++) mem[i] = rotl(32'h0123_4567, i);
      txn(16'h0000, -1, 1'b0, 2, 1'b1);

      // Back-to-back: a new start one cycle after the handshake, ready held high.
      b = 16'($urandom);
      txn(b, -1, 1'b0, 0, 1'b0);

      // Backpressure for 10 cycles.
      b = 16'($urandom);
      txn(b, -1, 1'b0, 10, 1'b0);

      // Address wrap at the top of memory.
      for (int i = 0; i < 19; i++) begin
         a = 16'hFFF8 + 16'(i);
         mem[a] = $urandom;
      end
      txn(16'hFFF8, -1, 1'b0, 1, 1'b0);

      // Spurious start in the middle of READ.
      b = 16'($urandom);
      txn(b, 7, 1'b0, 0, 1'b0);

      // Start coinciding with the handshake edge must be ignored.
      b = 16'($urandom);
      txn(b, -1, 1'b1, 0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("hs_start_ignored", {510'b0, out_valid, busy}, 512'd0);

      // Reset while rd_idx = 9.
      start        = 1'b1;
      message_addr = 16'($urandom);
      @(posedge clk);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      check("rst_mid_ctl", {494'b0, mem_addr, out_valid, busy}, 512'd0);
      check("rst_mid_blk1", blk1, 512'd0);
      b = 16'($urandom);
      txn(b, -1, 1'b0, 0, 1'b0);

      // Random mix.
      for (int r = 0; r < 6; r++) begin
         b = 16'($urandom);
         txn(b, int'($urandom_range(0, 30)) - 10, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)), 1'b0);
      end

      @(posedge clk);
      @(negedge clk);
      check("sb_empty", 512'(sb_q.size()), 512'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
